pq_driver: RTL

Command-side driver for the team's systolic min-priority queue. Accepts push/pop/replace commands over a valid/ready stream and issues them to the queue's strobe port (write, read, data, full, empty, head), never faster than the queue can re-sort. Returns popped heads over a valid/ready result stream and keeps a shadow occupancy count. It sits between the scheduler logic and the queue instance; the queue itself is unchanged.

---
 rtl/pq_driver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pq_driver.sv
// pq_driver: paced command driver for the systolic min-priority queue.
// Optional 2-entry result skid buffer when PQ_DRIVER_RES_SKID_EN is defined.
module pq_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 8,
  parameter int OP_GAP     = 2
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [1:0]                           i_cmd_op,
  input  logic [DATA_WIDTH-1:0]                i_cmd_data,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [DATA_WIDTH-1:0]                o_res_data,
  output logic                                 o_q_wrt,
  output logic                                 o_q_read,
  output logic [DATA_WIDTH-1:0]                o_q_data,
  input  logic                                 i_q_full,
  input  logic                                 i_q_empty,
  input  logic [DATA_WIDTH-1:0]                i_q_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]      o_count,
  output logic                                 o_err
);

  // state | meaning
  // IDLE  | waiting for a command; only state that can raise o_cmd_ready
  // ISSUE | one cycle; queue strobes driven, head captured, count updated
  // GAP   | OP_GAP-1 cycles of enforced idle so the queue can re-sort

  localparam int CW = $clog2(QUEUE_SIZE+1);
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  localparam bit         NO_GAP   = (OP_GAP <= 1);
  localparam logic [3:0] GAP_LOAD = (OP_GAP > 1) ? 4'(OP_GAP - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;

  logic [1:0] op_q;
  logic       full_q, empty_q, rej_q;

  logic cmd_acc;
  logic dec_wrt, dec_rd, dec_rej;
  logic res_push, res_pop, res_room;
  logic cnt_inc, cnt_dec;

  assign cmd_acc = i_cmd_valid && o_cmd_ready;

  always_comb begin
    dec_wrt = 1'b0;
    dec_rd  = 1'b0;
    dec_rej = 1'b0;
    unique case (i_cmd_op)
      OP_PUSH: begin
        dec_wrt = !i_q_full;
        dec_rej = i_q_full;
      end
      OP_POP: begin
        dec_rd  = !i_q_empty;
        dec_rej = i_q_empty;
      end
      OP_REPL: begin
        dec_wrt = 1'b1;
        dec_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q    <= OP_NOP;
      full_q  <= 1'b0;
      empty_q <= 1'b0;
      rej_q   <= 1'b0;
    end else if (cmd_acc) begin
      op_q    <= i_cmd_op;
      full_q  <= i_q_full;
      empty_q <= i_q_empty;
      rej_q   <= dec_rej;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (cmd_acc) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (rej_q || (op_q == OP_NOP) || NO_GAP) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered off the accept cycle so they land exactly in ISSUE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_q_wrt  <= 1'b0;
      o_q_read <= 1'b0;
      o_q_data <= '0;
      o_err    <= 1'b0;
    end else begin
      o_q_wrt  <= cmd_acc && dec_wrt;
      o_q_read <= cmd_acc && dec_rd;
      o_q_data <= cmd_acc ? i_cmd_data : '0;
      o_err    <= cmd_acc && dec_rej;
    end
  end

  assign res_push = (state == ST_ISSUE) && ((op_q == OP_POP) || (op_q == OP_REPL)) && !empty_q;
  assign res_pop  = o_res_valid && i_res_ready;
  assign cnt_inc  = ((op_q == OP_PUSH) && !full_q) || ((op_q == OP_REPL) && empty_q);
  assign cnt_dec  = (op_q == OP_POP) && !empty_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      o_count <= '0;
    end else if (state == ST_ISSUE) begin
      if (cnt_inc)      o_count <= o_count + CW'(1);
      else if (cnt_dec) o_count <= o_count - CW'(1);
    end
  end

`ifdef PQ_DRIVER_RES_SKID_EN
  logic [DATA_WIDTH-1:0] res_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            res_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_mem[0] <= '0;
      res_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      res_cnt    <= 2'd0;
    end else begin
      if (res_push) begin
        res_mem[wr_ptr] <= i_q_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (res_pop) rd_ptr <= ~rd_ptr;
      res_cnt <= res_cnt + 2'(res_push) - 2'(res_pop);
    end
  end

  assign o_res_valid = (res_cnt != 2'd0);
  assign o_res_data  = res_mem[rd_ptr];
  assign res_room    = (res_cnt != 2'd2);
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
    end else if (res_push) begin
      o_res_valid <= 1'b1;
      o_res_data  <= i_q_data;
    end else if (res_pop) begin
      o_res_valid <= 1'b0;
    end
  end

  assign res_room = !o_res_valid;
`endif

  assign o_cmd_ready = (state == ST_IDLE) && res_room && !RST;

endmodule
